multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM of a multicycle RV32-style core. Each instruction is
//   walked through its states one clock at a time, and the FSM drives the
//   datapath write enables and mux selects for each state. The opcode in op
//   is the instruction register content. It is held stable for the whole
//   instruction.
//
// Configuration macro: MULTICYCLE_CTRL_MEM_HANDSHAKE_EN
//   defined   : mem_ready stalls FETCH, MEMREAD and MEMWRITE until it is 1.
//   undefined : mem_ready is ignored and treated as 1, so those states always
//               advance after one cycle.
//
// Ports
//   clk                  single clock, rising edge
//   reset                synchronous reset, active low
//   op[6:0]              opcode of the held instruction
//   zero                 ALU zero flag, used to decide a BEQ branch
//   mem_ready            memory accepted the current access this cycle
//   mem_valid            a memory access is requested this cycle
//   pc_write, ir_write,
//   reg_write, mem_write datapath write enables
//   adr_src              memory address select: 0 = PC, 1 = ALU result register
//   alu_src_a/b[1:0]     ALU operand selects
//   result_src[1:0]      result bus select
//   alu_op[1:0]          ALU decoder class
//   imm_src[1:0]         immediate format, decoded from op in every state
//   illegal              one-cycle pulse in DECODE on an unsupported opcode
//
// Handshake: the memory side uses valid/ready. A memory access completes on
//   a cycle where mem_valid and mem_ready are both 1. While mem_ready is 0,
//   the FSM stays in its state and every output holds its value.
// -----------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_valid,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t state_q, state_d;

  // Effective memory-ready. Without the handshake, memory is assumed to
  // always accept in one cycle, so the port is left unused.
  logic rdy;
`ifdef MULTICYCLE_CTRL_MEM_HANDSHAKE_EN
  assign rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign rdy = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_valid  = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 is computed and written in the same cycle the IR captures.
        mem_valid  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = rdy;
        pc_write   = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        // The ALU precomputes PC+imm here as a possible branch target.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_valid = 1'b1;
        adr_src   = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        // mem_write stays high for the whole wait, so the request is held stable.
        mem_valid = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // Jump target comes from the DECODE result. The ALU forms PC+4 as the link value.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // While reset is low, nothing may be written and no access may be requested.
    if (!reset) begin
      mem_valid = 1'b0;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Self-checking bench for multicycle_ctrl. A reference model describes each
//   instruction class as the list of phases it passes through. Every cycle,
//   the outputs the current phase should produce are compared with the DUT.
//   Phases that access memory repeat while a stall is in effect.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

`ifdef MULTICYCLE_CTRL_MEM_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BEQ = 7'b1100011;

  // mem_ready policies
  localparam int MR_RAND = 0;
  localparam int MR_ONE  = 1;
  localparam int MR_ZERO = 2;
  localparam int MR_LO3  = 3;  // three low cycles while in a data-memory phase

  // Bits that must be 0 while reset is low: mem_valid, the four write enables, illegal
  localparam logic [16:0] RST_MASK = 17'b11111_0_00_00_00_00_00_1;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] op = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_valid, pc_write, ir_write, reg_write, mem_write, adr_src, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op, imm_src;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_valid  (mem_valid),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .illegal    (illegal)
  );

  logic [16:0] obs;
  assign obs = {mem_valid, pc_write, ir_write, reg_write, mem_write, adr_src,
                alu_src_a, alu_src_b, result_src, alu_op, imm_src, illegal};

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] exp_q[$];

  task automatic check_vec(input string tag, input logic [16:0] e);
    logic [16:0] want;
    exp_q.push_back(e);
    want = exp_q.pop_front();
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h op=%b", tag, obs, want, op);
    end
  endtask

  // reference model
  function automatic bit is_legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == JAL) || (o == BEQ);
  endfunction

  function automatic bit waits_on_mem(input string s);
    return (s == "F") || (s == "MR") || (s == "MWR");
  endfunction

  function automatic logic [16:0] exp_out(input string s, input logic [6:0] o,
                                          input logic z, input logic mr);
    logic mv, pcw, irw, rw, mw, adr, ill, rdy;
    logic [1:0] a, b, rs, alu, imm;
    mv = 0; pcw = 0; irw = 0; rw = 0; mw = 0; adr = 0; ill = 0;
    a = 0; b = 0; rs = 0; alu = 0;
    rdy = HS ? mr : 1'b1;
    imm = (o == SW) ? 2'b01 : (o == BEQ) ? 2'b10 : (o == JAL) ? 2'b11 : 2'b00;
    if (s == "F") begin
      mv = 1; b = 2; rs = 2; irw = rdy; pcw = rdy;
    end else if (s == "D") begin
      a = 1; b = 1; ill = !is_legal(o);
    end else if (s == "MA") begin
      a = 2; b = 1;
    end else if (s == "MR") begin
      mv = 1; adr = 1;
    end else if (s == "MW") begin
      rs = 1; rw = 1;
    end else if (s == "MWR") begin
      mv = 1; adr = 1; mw = 1;
    end else if (s == "ER") begin
      a = 2; alu = 2;
    end else if (s == "EI") begin
      a = 2; b = 1; alu = 2;
    end else if (s == "AW") begin
      rw = 1;
    end else if (s == "J") begin
      a = 1; b = 2; pcw = 1;
    end else if (s == "B") begin
      a = 2; alu = 1; pcw = z;
    end
    return {mv, pcw, irw, rw, mw, adr, a, b, rs, alu, imm, ill};
  endfunction

  // driver tasks
  task automatic reset_cycle(input string tag);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    zero = 1'($urandom_range(0, 1));
    #1;
    n_cmp++;
    assert ((obs & RST_MASK) === 17'b0) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h under mask %h", tag, obs & RST_MASK, 17'b0, RST_MASK);
    end
  endtask

  // Runs one instruction from FETCH. zero_mode < 0 makes zero random.
  // abort_after > 0 stops after that many cycles, leaving the DUT mid-instruction.
  task automatic run_instr(input string tag, input logic [6:0] o, input int abort_after,
                           input int mr_mode, input int zero_mode);
    string steps[$];
    int cyc;
    int lo_cnt;
    bit aborted;
    cyc = 0; lo_cnt = 0; aborted = 0;
    if      (o == LW)  steps = '{"F", "D", "MA", "MR", "MW"};
    else if (o == SW)  steps = '{"F", "D", "MA", "MWR"};
    else if (o == RT)  steps = '{"F", "D", "ER", "AW"};
    else if (o == IT)  steps = '{"F", "D", "EI", "AW"};
    else if (o == JAL) steps = '{"F", "D", "J", "AW"};
    else if (o == BEQ) steps = '{"F", "D", "B"};
    else               steps = '{"F", "D"};
    while (steps.size() > 0 && cyc < 60) begin
      @(negedge clk);
      reset = 1'b1;
      op = o;
      zero = (zero_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(zero_mode);
      case (mr_mode)
        MR_ONE:  mem_ready = 1'b1;
        MR_ZERO: mem_ready = 1'b0;
        MR_LO3: begin
          if ((steps[0] == "MR" || steps[0] == "MWR") && lo_cnt < 3) begin
            mem_ready = 1'b0;
            lo_cnt++;
          end else mem_ready = 1'b1;
        end
        default: mem_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      check_vec($sformatf("%s_c%0d_%s", tag, cyc, steps[0]), exp_out(steps[0], o, zero, mem_ready));
      if (!(HS && !mem_ready && waits_on_mem(steps[0]))) void'(steps.pop_front());
      cyc++;
      if (abort_after > 0 && cyc == abort_after) begin
        aborted = 1;
        break;
      end
    end
    if (!aborted) begin
      n_cmp++;
      assert (steps.size() == 0) else begin
        n_bad++;
        $error("FAIL %s_budget: observed=%0d phases left expected=0", tag, steps.size());
      end
    end
  endtask

  initial begin
    logic [6:0] pick_op;
    int k;
    @(posedge clk);
    reset_cycle("rst_init0");
    reset_cycle("rst_init1");

    run_instr("lw",      LW,  0, MR_ONE, -1);
    run_instr("sw_wait", SW,  0, MR_LO3, -1);
    run_instr("beq_z1",  BEQ, 0, MR_ONE, 1);
    run_instr("beq_z0",  BEQ, 0, MR_ONE, 0);
    run_instr("ill",     7'b0000000, 0, MR_ONE, -1);
    run_instr("rtype",   RT,  0, MR_ONE, -1);
    run_instr("itype",   IT,  0, MR_RAND, -1);
    run_instr("jal",     JAL, 0, MR_RAND, -1);
    // reset lands in the first MEMREAD cycle, which is a wait when the handshake is enabled
    run_instr("lw_abort", LW, 4, MR_LO3, -1);
    reset_cycle("rst_memread");
    run_instr("lw_after", LW, 0, MR_RAND, -1);
    run_instr("ill_abort", 7'b1111111, 2, MR_ONE, -1);
    reset_cycle("rst_decode");
`ifndef MULTICYCLE_CTRL_MEM_HANDSHAKE_EN
    run_instr("r_mr0", RT, 0, MR_ZERO, -1);
`endif

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 6))
        0: pick_op = LW;
        1: pick_op = SW;
        2: pick_op = RT;
        3: pick_op = IT;
        4: pick_op = JAL;
        5: pick_op = BEQ;
        default: pick_op = 7'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(1, 4);
        run_instr($sformatf("rnd%0d_ab", i), pick_op, k, MR_RAND, -1);
        reset_cycle($sformatf("rnd%0d_rst", i));
      end else begin
        run_instr($sformatf("rnd%0d", i), pick_op, 0, MR_RAND, -1);
      end
    end

    @(negedge clk);
    reset = 1'b1;
    op = RT;
    mem_ready = 1'b1;
    #1;
    check_vec("final_fetch", exp_out("F", RT, zero, 1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
